bmd_to_req: RTL and testbench

//  Turn-off requester: the initiating end of the PME_Turn_Off / PME_TO_Ack handshake.
//  On a power-down request it waits for outstanding non-posted requests to drain,

---
 rtl/bmd_to_req_pkg.sv | 21 ++
 rtl/bmd_to_req_if.sv | 29 ++
 rtl/bmd_np_tracker.sv | 41 ++++
 rtl/bmd_to_req.sv | 98 +++++++++
 tb/tb_bmd_to_req.sv | 371 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bmd_to_req_pkg.sv
`default_nettype none
// ============================================================================
// Module : bmd_to_req_pkg
// Brief  : Shared message codes and FSM state encoding for the turn-off requester.
// Rev    : 1.0  initial release
// ============================================================================
package bmd_to_req_pkg;

    localparam logic [7:0] PME_TURN_OFF_CODE = 8'h19;

    typedef enum logic [2:0] {
        TO_IDLE     = 3'd0,
        TO_DRAIN    = 3'd1,
        TO_SEND     = 3'd2,
        TO_WAIT_ACK = 3'd3,
        TO_DONE     = 3'd4,
        TO_TMO      = 3'd5
    } to_state_e;

endpackage
`default_nettype wire

// File: rtl/bmd_to_req_if.sv
`default_nettype none
// ============================================================================
// Module : bmd_to_req_if
// Brief  : Message handshake between the turn-off requester and the TX/RX engines.
// Rev    : 1.0  initial release
// ============================================================================
interface bmd_to_req_if;

    logic       msg_req_o;
    logic [7:0] msg_code_o;
    logic       msg_ack_i;
    logic       pme_to_ack_i;

    modport master (
        output msg_req_o,
        output msg_code_o,
        input  msg_ack_i,
        input  pme_to_ack_i
    );

    modport slave (
        input  msg_req_o,
        input  msg_code_o,
        output msg_ack_i,
        output pme_to_ack_i
    );

endinterface
`default_nettype wire

// File: rtl/bmd_np_tracker.sv
`default_nettype none
// ============================================================================
// Module : bmd_np_tracker
// Brief  : Saturating up/down count of outstanding non-posted requests.
// Rev    : 1.0  initial release
// ============================================================================
module bmd_np_tracker #(
    parameter int OUT_W = 4
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             issue_i,
    input  wire logic             done_i,
    output logic      [OUT_W-1:0] count_o
);

    logic [OUT_W-1:0] count_q;
    logic [OUT_W-1:0] count_d;

    // Simultaneous issue and completion cancel; both ends clamp instead of wrapping.
    always_comb begin
        count_d = count_q;
        if (issue_i && !done_i && (count_q != '1)) begin
            count_d = count_q + OUT_W'(1);
        end else if (done_i && !issue_i && (count_q != '0)) begin
            count_d = count_q - OUT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/bmd_to_req.sv
`default_nettype none
// ============================================================================
// Module : bmd_to_req
// Brief  : PME_Turn_Off requester: drain NP requests, send the message, await ack.
// Rev    : 1.0  initial release
// ============================================================================
module bmd_to_req
    import bmd_to_req_pkg::*;
#(
    parameter int OUT_W   = 4,
    parameter int TMO_W   = 20,
    parameter int TMO_CYC = 1000000
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             turnoff_req_i,
    input  wire logic             np_req_issue_i,
    input  wire logic             np_cpl_done_i,
    bmd_to_req_if.master          msg_if,
    output logic                  busy_o,
    output logic                  turnoff_done_o,
    output logic                  turnoff_tmo_o,
    output logic      [OUT_W-1:0] outstanding_o
);

    to_state_e        state_q;
    to_state_e        state_d;
    logic [TMO_W-1:0] tmo_cnt_q;
    logic [TMO_W-1:0] tmo_cnt_d;
    logic [OUT_W-1:0] outstanding;
    logic             tmo_hit;

    bmd_np_tracker #(
        .OUT_W (OUT_W)
    ) u_np_tracker (
        .clk     (clk),
        .rst     (rst),
        .issue_i (np_req_issue_i),
        .done_i  (np_cpl_done_i),
        .count_o (outstanding)
    );

    assign tmo_hit = (tmo_cnt_q == TMO_W'(TMO_CYC - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            TO_IDLE: begin
                if (turnoff_req_i) state_d = TO_DRAIN;
            end
            TO_DRAIN: begin
                if (!turnoff_req_i)          state_d = TO_IDLE;
                else if (outstanding == '0)  state_d = TO_SEND;
                else if (tmo_hit)            state_d = TO_TMO;
            end
            TO_SEND: begin
                // Once presented, the request stays up until the TX engine takes it.
                if (msg_if.msg_ack_i) state_d = turnoff_req_i ? TO_WAIT_ACK : TO_IDLE;
            end
            TO_WAIT_ACK: begin
                if (!turnoff_req_i)           state_d = TO_IDLE;
                else if (msg_if.pme_to_ack_i) state_d = TO_DONE;
                else if (tmo_hit)             state_d = TO_TMO;
            end
            TO_DONE, TO_TMO: begin
                if (!turnoff_req_i) state_d = TO_IDLE;
            end
            default: state_d = TO_IDLE;
        endcase
    end

    // Counter restarts on entry to a timed state and advances while it stays there.
    always_comb begin
        tmo_cnt_d = '0;
        if ((state_d == state_q) && ((state_q == TO_DRAIN) || (state_q == TO_WAIT_ACK))) begin
            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= TO_IDLE;
            tmo_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    assign msg_if.msg_req_o  = (state_q == TO_SEND);
    assign msg_if.msg_code_o = PME_TURN_OFF_CODE;
    assign busy_o            = (state_q != TO_IDLE);
    assign turnoff_done_o    = (state_q == TO_DONE);
    assign turnoff_tmo_o     = (state_q == TO_TMO);
    assign outstanding_o     = outstanding;

endmodule
`default_nettype wire

// File: tb/tb_bmd_to_req.sv
`default_nettype none
// ============================================================================
// Module : tb_bmd_to_req
// Brief  : Self-checking bench for the PME_Turn_Off requester.
// Rev    : 1.0  initial release
// ============================================================================
module tb_bmd_to_req;

    localparam int OUT_W   = 4;
    localparam int TMO_W   = 20;
    localparam int TMO_CYC = 16;

    // {busy, msg_req, done, tmo}
    localparam logic [3:0] P_IDLE = 4'b0000;
    localparam logic [3:0] P_BUSY = 4'b1000;
    localparam logic [3:0] P_SEND = 4'b1100;
    localparam logic [3:0] P_DONE = 4'b1010;
    localparam logic [3:0] P_TMO  = 4'b1001;

    logic             clk = 1'b0;
    logic             rst;
    logic             req;
    logic             issue;
    logic             cpl;
    logic             busy;
    logic             done;
    logic             tmo;
    logic [OUT_W-1:0] outst;
    int               errors = 0;
    int               checks = 0;

    bmd_to_req_if bus();

    bmd_to_req #(
        .OUT_W   (OUT_W),
        .TMO_W   (TMO_W),
        .TMO_CYC (TMO_CYC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .turnoff_req_i  (req),
        .np_req_issue_i (issue),
        .np_cpl_done_i  (cpl),
        .msg_if         (bus),
        .busy_o         (busy),
        .turnoff_done_o (done),
        .turnoff_tmo_o  (tmo),
        .outstanding_o  (outst)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] outs();
        return {busy, bus.msg_req_o, done, tmo};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Stimulus only: leaves the DUT in its first WAIT_ACK cycle (outstanding must be 0).
    task automatic drive_to_wait_ack();
        req = 1'b1;
        step();
        step();
        bus.msg_ack_i = 1'b1;
        step();
        bus.msg_ack_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++;
        if (outs() !== P_IDLE) begin errors++; $display("FAIL reset_flags: got %b want %b", outs(), P_IDLE); end
        checks++;
        if (outst !== 4'd0) begin errors++; $display("FAIL reset_outstanding: got %0d want 0", outst); end
        checks++;
        if (bus.msg_code_o !== 8'h19) begin errors++; $display("FAIL reset_code: got %h want 19", bus.msg_code_o); end
        rst = 1'b0;
        step();
        checks++;
        if (outs() !== P_IDLE) begin errors++; $display("FAIL reset_release: got %b want %b", outs(), P_IDLE); end
    endtask

    task automatic test_basic();
        req = 1'b1;
        step();
        checks++;
        if (outs() !== P_BUSY) begin errors++; $display("FAIL basic_drain_n1: got %b want %b", outs(), P_BUSY); end
        step();
        checks++;
        if (outs() !== P_SEND) begin errors++; $display("FAIL basic_msgreq_n2: got %b want %b", outs(), P_SEND); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (outs() !== P_SEND) begin errors++; $display("FAIL basic_msgreq_hold: got %b want %b", outs(), P_SEND); end
        end
        bus.msg_ack_i = 1'b1;
        step();
        bus.msg_ack_i = 1'b0;
        checks++;
        if (outs() !== P_BUSY) begin errors++; $display("FAIL basic_wait_ack: got %b want %b", outs(), P_BUSY); end
        for (int i = 0; i < 4; i++) step();
        bus.pme_to_ack_i = 1'b1;
        step();
        bus.pme_to_ack_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (outs() !== P_DONE) begin errors++; $display("FAIL basic_done_held: got %b want %b", outs(), P_DONE); end
            step();
        end
        req = 1'b0;
        step();
        checks++;
        if (outs() !== P_IDLE) begin errors++; $display("FAIL basic_release: got %b want %b", outs(), P_IDLE); end
    endtask

    task automatic test_drain();
        issue = 1'b1;
        for (int i = 0; i < 3; i++) step();
        issue = 1'b0;
        req   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if ({outs(), outst} !== {P_BUSY, 4'd3}) begin
                errors++; $display("FAIL drain_hold: got %b/%0d want %b/3", outs(), outst, P_BUSY);
            end
        end
        for (int i = 0; i < 3; i++) begin
            cpl = 1'b1;
            step();
            cpl = 1'b0;
        end
        checks++;
        if ({outs(), outst} !== {P_BUSY, 4'd0}) begin
            errors++; $display("FAIL drain_emptied: got %b/%0d want %b/0", outs(), outst, P_BUSY);
        end
        step();
        checks++;
        if (outs() !== P_SEND) begin errors++; $display("FAIL drain_to_send: got %b want %b", outs(), P_SEND); end
        bus.msg_ack_i = 1'b1;
        step();
        bus.msg_ack_i = 1'b0;
        req = 1'b0;
        step();
    endtask

    task automatic test_timeout();
        drive_to_wait_ack();
        for (int i = 1; i < TMO_CYC; i++) begin
            step();
            checks++;
            if (outs() !== P_BUSY) begin errors++; $display("FAIL tmo_wait_early cycle %0d: got %b want %b", i, outs(), P_BUSY); end
        end
        step();
        checks++;
        if (outs() !== P_TMO) begin errors++; $display("FAIL tmo_wait_at_limit: got %b want %b", outs(), P_TMO); end
        bus.pme_to_ack_i = 1'b1;
        step();
        bus.pme_to_ack_i = 1'b0;
        checks++;
        if (outs() !== P_TMO) begin errors++; $display("FAIL tmo_sticky: got %b want %b", outs(), P_TMO); end
        req = 1'b0;
        step();
        checks++;
        if (outs() !== P_IDLE) begin errors++; $display("FAIL tmo_release: got %b want %b", outs(), P_IDLE); end

        drive_to_wait_ack();
        for (int i = 1; i < TMO_CYC; i++) step();
        bus.pme_to_ack_i = 1'b1;
        step();
        bus.pme_to_ack_i = 1'b0;
        checks++;
        if (outs() !== P_DONE) begin errors++; $display("FAIL tmo_ack_wins: got %b want %b", outs(), P_DONE); end
        req = 1'b0;
        step();

        issue = 1'b1;
        step();
        issue = 1'b0;
        req   = 1'b1;
        step();
        for (int i = 1; i < TMO_CYC; i++) begin
            step();
            checks++;
            if (outs() !== P_BUSY) begin errors++; $display("FAIL tmo_drain_early cycle %0d: got %b want %b", i, outs(), P_BUSY); end
        end
        step();
        checks++;
        if (outs() !== P_TMO) begin errors++; $display("FAIL tmo_drain_at_limit: got %b want %b", outs(), P_TMO); end
        req = 1'b0;
        cpl = 1'b1;
        step();
        cpl = 1'b0;
        step();
    endtask

    task automatic test_drop();
        req = 1'b1;
        step();
        step();
        req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (outs() !== P_SEND) begin errors++; $display("FAIL drop_send_hold: got %b want %b", outs(), P_SEND); end
        end
        bus.msg_ack_i = 1'b1;
        step();
        bus.msg_ack_i = 1'b0;
        checks++;
        if (outs() !== P_IDLE) begin errors++; $display("FAIL drop_send_idle: got %b want %b", outs(), P_IDLE); end

        issue = 1'b1;
        step();
        issue = 1'b0;
        req   = 1'b1;
        step();
        step();
        req = 1'b0;
        step();
        checks++;
        if (outs() !== P_IDLE) begin errors++; $display("FAIL drop_drain_idle: got %b want %b", outs(), P_IDLE); end
        cpl = 1'b1;
        step();
        cpl = 1'b0;

        bus.msg_ack_i    = 1'b1;
        bus.pme_to_ack_i = 1'b1;
        step();
        bus.msg_ack_i    = 1'b0;
        bus.pme_to_ack_i = 1'b0;
        step();
        checks++;
        if ({outs(), outst} !== {P_IDLE, 4'd0}) begin
            errors++; $display("FAIL drop_stray_ignored: got %b/%0d want %b/0", outs(), outst, P_IDLE);
        end
    endtask

    task automatic test_counter();
        int model;
        int bias_i;
        int bias_d;
        model = 0;
        issue = 1'b1;
        for (int i = 0; i < 18; i++) step();
        issue = 1'b0;
        checks++;
        if (outst !== 4'd15) begin errors++; $display("FAIL cnt_saturate: got %0d want 15", outst); end
        issue = 1'b1;
        cpl   = 1'b1;
        step();
        checks++;
        if (outst !== 4'd15) begin errors++; $display("FAIL cnt_simultaneous: got %0d want 15", outst); end
        model = 15;
        for (int ph = 0; ph < 4; ph++) begin
            bias_i = (ph % 2 == 0) ? 25 : 80;
            bias_d = (ph % 2 == 0) ? 80 : 25;
            for (int i = 0; i < 60; i++) begin
                issue = ($urandom_range(0, 99) < bias_i) ? 1'b1 : 1'b0;
                cpl   = ($urandom_range(0, 99) < bias_d) ? 1'b1 : 1'b0;
                step();
                if (issue && !cpl)      model = (model < 15) ? model + 1 : 15;
                else if (cpl && !issue) model = (model > 0) ? model - 1 : 0;
                checks++;
                if (outst !== OUT_W'(model)) begin errors++; $display("FAIL cnt_random: got %0d want %0d", outst, model); end
            end
        end
        issue = 1'b0;
        cpl   = 1'b1;
        for (int i = 0; i < 18; i++) step();
        cpl = 1'b0;
        checks++;
        if (outst !== 4'd0) begin errors++; $display("FAIL cnt_floor: got %0d want 0", outst); end
    endtask

    task automatic test_random_flows();
        int n;
        int a;
        int pd;
        logic [3:0] exp;
        for (int it = 0; it < 8; it++) begin
            n = $urandom_range(0, 4);
            issue = 1'b1;
            for (int i = 0; i < n; i++) step();
            issue = 1'b0;
            req   = 1'b1;
            step();
            for (int j = 0; j < n; j++) begin
                step();
                cpl = 1'b1;
                step();
                cpl = 1'b0;
                checks++;
                if ({outs(), outst} !== {P_BUSY, OUT_W'(n - 1 - j)}) begin
                    errors++; $display("FAIL flow_drain: got %b/%0d want %b/%0d", outs(), outst, P_BUSY, n - 1 - j);
                end
            end
            step();
            checks++;
            if (outs() !== P_SEND) begin errors++; $display("FAIL flow_msgreq n=%0d: got %b want %b", n, outs(), P_SEND); end
            a = $urandom_range(0, 4);
            for (int i = 0; i < a; i++) step();
            bus.msg_ack_i = 1'b1;
            step();
            bus.msg_ack_i = 1'b0;
            pd = $urandom_range(0, TMO_CYC + 3);
            for (int k = 0; k < TMO_CYC; k++) begin
                if (k == pd) bus.pme_to_ack_i = 1'b1;
                step();
                bus.pme_to_ack_i = 1'b0;
                if (k == pd)                exp = P_DONE;
                else if (k == TMO_CYC - 1)  exp = P_TMO;
                else                        exp = P_BUSY;
                checks++;
                if (outs() !== exp) begin errors++; $display("FAIL flow_wait pd=%0d k=%0d: got %b want %b", pd, k, outs(), exp); end
                if (exp != P_BUSY) break;
            end
            req = 1'b0;
            step();
            checks++;
            if (outs() !== P_IDLE) begin errors++; $display("FAIL flow_release: got %b want %b", outs(), P_IDLE); end
        end
    endtask

    task automatic test_reset_mid();
        drive_to_wait_ack();
        issue = 1'b1;
        step();
        issue = 1'b0;
        rst = 1'b1;
        step();
        checks++;
        if ({outs(), outst, bus.msg_code_o} !== {P_IDLE, 4'd0, 8'h19}) begin
            errors++; $display("FAIL rstmid_clear: got %b/%0d/%h want %b/0/19", outs(), outst, bus.msg_code_o, P_IDLE);
        end
        rst = 1'b0;
        req = 1'b0;
        bus.pme_to_ack_i = 1'b1;
        step();
        bus.pme_to_ack_i = 1'b0;
        step();
        checks++;
        if (outs() !== P_IDLE) begin errors++; $display("FAIL rstmid_stray_ack: got %b want %b", outs(), P_IDLE); end
    endtask

    initial begin
        rst              = 1'b1;
        req              = 1'b0;
        issue            = 1'b0;
        cpl              = 1'b0;
        bus.msg_ack_i    = 1'b0;
        bus.pme_to_ack_i = 1'b0;
        test_reset();
        test_basic();
        test_drain();
        test_timeout();
        test_drop();
        test_counter();
        test_random_flows();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
